// File: rtl/obi_xbar.sv
// OBI crossbar: MASTERS initiators to SLAVES targets, with per-slave round-robin arbitration,
// per-slave response ID FIFOs and a decode-error responder for unmapped addresses.
module obi_xbar #(
   parameter int unsigned MASTERS     = 3,
   parameter int unsigned SLAVES      = 3,
   parameter int unsigned OUTSTANDING = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [MASTERS-1:0]             master_req_i,
   output logic [MASTERS-1:0]             master_gnt_o,
   output logic [MASTERS-1:0]             master_rvalid_o,
   output logic [MASTERS-1:0]             master_err_o,
   input  logic [MASTERS-1:0]             master_we_i,
   input  logic [MASTERS-1:0][3:0]        master_be_i,
   input  logic [MASTERS-1:0][31:0]       master_addr_i,
   input  logic [MASTERS-1:0][31:0]       master_wdata_i,
   output logic [MASTERS-1:0][31:0]       master_rdata_o,
   input  logic [SLAVES-1:0][31:0]        slave_addr_mask_i,
   input  logic [SLAVES-1:0][31:0]        slave_addr_base_i,
   output logic [SLAVES-1:0]              slave_req_o,
   input  logic [SLAVES-1:0]              slave_gnt_i,
   input  logic [SLAVES-1:0]              slave_rvalid_i,
   output logic [SLAVES-1:0]              slave_we_o,
   output logic [SLAVES-1:0][3:0]         slave_be_o,
   output logic [SLAVES-1:0][31:0]        slave_addr_o,
   output logic [SLAVES-1:0][31:0]        slave_wdata_o,
   input  logic [SLAVES-1:0][31:0]        slave_rdata_i
);

   localparam int unsigned MW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
   localparam int unsigned SW = $clog2(SLAVES + 1);
   localparam int unsigned PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
   localparam int unsigned CW = $clog2(OUTSTANDING + 1);

   logic [MASTERS-1:0][SW-1:0]               dec;
   logic [MASTERS-1:0][SW-1:0]               tgt;
   logic [MASTERS-1:0][CW-1:0]               cnt;
   logic [MASTERS-1:0]                       active;
   logic [MASTERS-1:0]                       gnt;
   logic [MASTERS-1:0]                       rvalid;
   logic [MASTERS-1:0][31:0]                 rdata;
   logic [MASTERS-1:0]                       err_pend;

   logic [SLAVES-1:0][MW-1:0]                ptr;
   logic [SLAVES-1:0][MW-1:0]                win;
   logic [SLAVES-1:0]                        found;
   logic [SLAVES-1:0]                        hs;
   logic [SLAVES-1:0]                        pop;
   logic [SLAVES-1:0][OUTSTANDING-1:0][MW-1:0] fifo;
   logic [SLAVES-1:0][PW-1:0]                wr_ptr;
   logic [SLAVES-1:0][PW-1:0]                rd_ptr;
   logic [SLAVES-1:0][CW-1:0]                fcnt;
   logic [MW-1:0]                            idx;

   // Address decode and per-master blocking; reverse scan lets the lowest hit win.
   always_comb begin
      for (int unsigned m = 0; m < MASTERS; m++) begin
         dec[m] = SW'(SLAVES);
         for (int unsigned i = 0; i < SLAVES; i++) begin
            if ((master_addr_i[m] & slave_addr_mask_i[SLAVES-1-i]) == slave_addr_base_i[SLAVES-1-i])
               dec[m] = SW'(SLAVES - 1 - i);
         end
         active[m] = master_req_i[m] && !rst_i &&
                     (cnt[m] != CW'(OUTSTANDING)) &&
                     !((cnt[m] != '0) && (dec[m] != tgt[m]));
      end
   end

   // Round-robin arbitration starting at ptr[s], plus request muxing
   always_comb begin
      idx = '0;
      for (int unsigned s = 0; s < SLAVES; s++) begin
         found[s] = 1'b0;
         win[s]   = '0;
         for (int unsigned k = 0; k < MASTERS; k++) begin
            idx = MW'((32'(ptr[s]) + k) % MASTERS);
            if (!found[s] && active[idx] && (dec[idx] == SW'(s))) begin
               found[s] = 1'b1;
               win[s]   = idx;
            end
         end
         slave_req_o[s]   = found[s] && (fcnt[s] != CW'(OUTSTANDING));
         hs[s]            = slave_req_o[s] && slave_gnt_i[s];
         slave_we_o[s]    = 1'b0;
         slave_be_o[s]    = '0;
         slave_addr_o[s]  = '0;
         slave_wdata_o[s] = '0;
         if (found[s]) begin
            slave_we_o[s]    = master_we_i[win[s]];
            slave_be_o[s]    = master_be_i[win[s]];
            slave_addr_o[s]  = master_addr_i[win[s]];
            slave_wdata_o[s] = master_wdata_i[win[s]];
         end
         pop[s] = slave_rvalid_i[s] && (fcnt[s] != '0) && !rst_i;
      end
   end

   // Grant and response routing back to the masters
   always_comb begin
      for (int unsigned m = 0; m < MASTERS; m++) begin
         gnt[m]    = active[m] && (dec[m] == SW'(SLAVES));
         rvalid[m] = err_pend[m] && !rst_i;
         rdata[m]  = '0;
         for (int unsigned s = 0; s < SLAVES; s++) begin
            if (hs[s] && (win[s] == MW'(m)))
               gnt[m] = 1'b1;
            if (pop[s] && (fifo[s][rd_ptr[s]] == MW'(m))) begin
               rvalid[m] = 1'b1;
               rdata[m]  = slave_rdata_i[s];
            end
         end
      end
   end

   assign master_gnt_o    = gnt;
   assign master_rvalid_o = rvalid;
   assign master_rdata_o  = rdata;
   assign master_err_o    = err_pend & ~{MASTERS{rst_i}};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr      <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fcnt     <= '0;
         cnt      <= '0;
         tgt      <= '0;
         err_pend <= '0;
      end else begin
         for (int unsigned s = 0; s < SLAVES; s++) begin
            if (hs[s]) begin
               fifo[s][wr_ptr[s]] <= win[s];
               wr_ptr[s] <= (wr_ptr[s] == PW'(OUTSTANDING - 1)) ? '0 : wr_ptr[s] + 1'b1;
               ptr[s]    <= (win[s] == MW'(MASTERS - 1)) ? '0 : win[s] + 1'b1;
            end
            if (pop[s])
               rd_ptr[s] <= (rd_ptr[s] == PW'(OUTSTANDING - 1)) ? '0 : rd_ptr[s] + 1'b1;
            if (hs[s] && !pop[s])
               fcnt[s] <= fcnt[s] + 1'b1;
            else if (!hs[s] && pop[s])
               fcnt[s] <= fcnt[s] - 1'b1;
         end
         for (int unsigned m = 0; m < MASTERS; m++) begin
            if (gnt[m])
               tgt[m] <= dec[m];
            if (gnt[m] && !rvalid[m])
               cnt[m] <= cnt[m] + 1'b1;
            else if (!gnt[m] && rvalid[m])
               cnt[m] <= cnt[m] - 1'b1;
            err_pend[m] <= active[m] && (dec[m] == SW'(SLAVES));
         end
      end
   end

endmodule

// File: tb/tb_obi_xbar.sv
// Directed bench for obi_xbar: 3 masters, ROM/RAM/PERIPH at 0x0/0x1/0x2 in the top nibble.
module tb_obi_xbar;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic [2:0]        master_req_i;
   logic [2:0]        master_gnt_o;
   logic [2:0]        master_rvalid_o;
   logic [2:0]        master_err_o;
   logic [2:0]        master_we_i;
   logic [2:0][3:0]   master_be_i;
   logic [2:0][31:0]  master_addr_i;
   logic [2:0][31:0]  master_wdata_i;
   logic [2:0][31:0]  master_rdata_o;
   logic [2:0][31:0]  slave_addr_mask_i;
   logic [2:0][31:0]  slave_addr_base_i;
   logic [2:0]        slave_req_o;
   logic [2:0]        slave_gnt_i;
   logic [2:0]        slave_rvalid_i;
   logic [2:0]        slave_we_o;
   logic [2:0][3:0]   slave_be_o;
   logic [2:0][31:0]  slave_addr_o;
   logic [2:0][31:0]  slave_wdata_o;
   logic [2:0][31:0]  slave_rdata_i;

   int vecs = 0;
   int errs = 0;

   obi_xbar #(.MASTERS(3), .SLAVES(3), .OUTSTANDING(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .master_req_i(master_req_i), .master_gnt_o(master_gnt_o),
      .master_rvalid_o(master_rvalid_o), .master_err_o(master_err_o),
      .master_we_i(master_we_i), .master_be_i(master_be_i),
      .master_addr_i(master_addr_i), .master_wdata_i(master_wdata_i),
      .master_rdata_o(master_rdata_o),
      .slave_addr_mask_i(slave_addr_mask_i), .slave_addr_base_i(slave_addr_base_i),
      .slave_req_o(slave_req_o), .slave_gnt_i(slave_gnt_i),
      .slave_rvalid_i(slave_rvalid_i), .slave_we_o(slave_we_o),
      .slave_be_o(slave_be_o), .slave_addr_o(slave_addr_o),
      .slave_wdata_o(slave_wdata_o), .slave_rdata_i(slave_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   // Advance to the falling edge and return all stimulus to idle
   task automatic cyc();
      @(negedge clk_i);
      master_req_i   = '0;
      master_we_i    = '0;
      master_be_i    = '0;
      master_addr_i  = '0;
      master_wdata_i = '0;
      slave_gnt_i    = '0;
      slave_rvalid_i = '0;
      slave_rdata_i  = '0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      cyc();
      master_req_i = 3'b111;
      master_addr_i[0] = 32'h1000_0000;
      master_addr_i[1] = 32'hF000_0000;
      slave_gnt_i = 3'b111;
      slave_rvalid_i = 3'b111;
      #1;
      vecs++; if (master_gnt_o !== 3'b000) begin errs++; $display("FAIL reset_gnt: got %b expected 000", master_gnt_o); end
      vecs++; if (master_rvalid_o !== 3'b000) begin errs++; $display("FAIL reset_rvalid: got %b expected 000", master_rvalid_o); end
      vecs++; if (slave_req_o !== 3'b000) begin errs++; $display("FAIL reset_slave_req: got %b expected 000", slave_req_o); end
      vecs++; if (slave_addr_o[1] !== 32'h0) begin errs++; $display("FAIL reset_slave_addr: got %h expected 0", slave_addr_o[1]); end
      cyc();
      rst_i = 1'b0;
   endtask

   task automatic test_single_read();
      cyc();
      master_req_i[0] = 1'b1;
      master_addr_i[0] = 32'h1000_0000;
      master_be_i[0] = 4'hF;
      slave_gnt_i[1] = 1'b1;
      #1;
      vecs++; if (slave_req_o !== 3'b010) begin errs++; $display("FAIL sr_slave_req: got %b expected 010", slave_req_o); end
      vecs++; if (slave_addr_o[1] !== 32'h1000_0000) begin errs++; $display("FAIL sr_addr: got %h expected 10000000", slave_addr_o[1]); end
      vecs++; if (slave_be_o[1] !== 4'hF) begin errs++; $display("FAIL sr_be: got %h expected f", slave_be_o[1]); end
      vecs++; if (master_gnt_o !== 3'b001) begin errs++; $display("FAIL sr_gnt: got %b expected 001", master_gnt_o); end
      cyc();
      slave_rvalid_i[1] = 1'b1;
      slave_rdata_i[1] = 32'h1234_5678;
      #1;
      vecs++; if (master_rvalid_o !== 3'b001) begin errs++; $display("FAIL sr_rvalid: got %b expected 001", master_rvalid_o); end
      vecs++; if (master_rdata_o[0] !== 32'h1234_5678) begin errs++; $display("FAIL sr_rdata: got %h expected 12345678", master_rdata_o[0]); end
      vecs++; if (master_err_o !== 3'b000) begin errs++; $display("FAIL sr_err: got %b expected 000", master_err_o); end
   endtask

   task automatic test_round_robin();
      int ng [3] = '{0, 0, 0};
      logic [2:0] exp_g;
      logic [2:0] exp_r;
      for (int c = 0; c < 6; c++) begin
         cyc();
         master_req_i = 3'b111;
         master_addr_i[0] = 32'h0000_0100;
         master_addr_i[1] = 32'h0000_0200;
         master_addr_i[2] = 32'h0000_0300;
         slave_gnt_i[0] = 1'b1;
         if (c > 0) begin
            slave_rvalid_i[0] = 1'b1;
            slave_rdata_i[0] = 32'hA000_0000 + 32'(c);
         end
         #1;
         exp_g = 3'b001 << (c % 3);
         vecs++; if (master_gnt_o !== exp_g) begin errs++; $display("FAIL rr_gnt c%0d: got %b expected %b", c, master_gnt_o, exp_g); end
         for (int m = 0; m < 3; m++) if (master_gnt_o[m]) ng[m]++;
         if (c > 0) begin
            exp_r = 3'b001 << ((c - 1) % 3);
            vecs++; if (master_rvalid_o !== exp_r) begin errs++; $display("FAIL rr_rvalid c%0d: got %b expected %b", c, master_rvalid_o, exp_r); end
         end
      end
      cyc();
      slave_rvalid_i[0] = 1'b1;
      slave_rdata_i[0] = 32'hA000_0006;
      #1;
      vecs++; if (master_rvalid_o !== 3'b100) begin errs++; $display("FAIL rr_last_rvalid: got %b expected 100", master_rvalid_o); end
      vecs++; if (master_rdata_o[2] !== 32'hA000_0006) begin errs++; $display("FAIL rr_last_rdata: got %h expected a0000006", master_rdata_o[2]); end
      for (int m = 0; m < 3; m++) begin
         vecs++; if (ng[m] != 2) begin errs++; $display("FAIL rr_count m%0d: got %0d expected 2", m, ng[m]); end
      end
   endtask

   task automatic test_outstanding();
      for (int c = 0; c < 5; c++) begin
         cyc();
         master_req_i[0] = 1'b1;
         master_addr_i[0] = (c < 2) ? 32'h1000_0000 + 32'(4 * c) : 32'h1000_0008;
         slave_gnt_i[1] = 1'b1;
         if (c == 3) begin
            slave_rvalid_i[1] = 1'b1;
            slave_rdata_i[1] = 32'hB000_0000;
         end
         #1;
         vecs++; if (master_gnt_o[0] !== (c != 2 && c != 3)) begin errs++; $display("FAIL os_gnt c%0d: got %b expected %b", c, master_gnt_o[0], (c != 2 && c != 3)); end
         if (c == 2) begin
            vecs++; if (slave_req_o[1] !== 1'b0) begin errs++; $display("FAIL os_blocked_req: got %b expected 0", slave_req_o[1]); end
         end
         if (c == 3) begin
            vecs++; if (master_rvalid_o[0] !== 1'b1 || master_rdata_o[0] !== 32'hB000_0000) begin errs++; $display("FAIL os_resp0: got %b/%h expected 1/b0000000", master_rvalid_o[0], master_rdata_o[0]); end
         end
         if (c == 4) begin
            vecs++; if (slave_addr_o[1] !== 32'h1000_0008) begin errs++; $display("FAIL os_third_addr: got %h expected 10000008", slave_addr_o[1]); end
         end
      end
      for (int c = 1; c < 3; c++) begin
         cyc();
         slave_rvalid_i[1] = 1'b1;
         slave_rdata_i[1] = 32'hB000_0000 + 32'(c);
         #1;
         vecs++; if (master_rvalid_o[0] !== 1'b1 || master_rdata_o[0] !== 32'hB000_0000 + 32'(c)) begin errs++; $display("FAIL os_resp%0d: got %b/%h expected 1/%h", c, master_rvalid_o[0], master_rdata_o[0], 32'hB000_0000 + 32'(c)); end
      end
   endtask

   task automatic test_target_switch();
      cyc();
      master_req_i[0] = 1'b1;
      master_addr_i[0] = 32'h1000_0040;
      slave_gnt_i[1] = 1'b1;
      #1;
      vecs++; if (master_gnt_o[0] !== 1'b1) begin errs++; $display("FAIL ts_ram_gnt: got %b expected 1", master_gnt_o[0]); end
      for (int c = 0; c < 4; c++) begin
         cyc();
         if (c < 3) begin
            master_req_i[0] = 1'b1;
            master_addr_i[0] = 32'h0000_0200;
            slave_gnt_i[0] = 1'b1;
         end
         if (c == 2) begin
            slave_rvalid_i[1] = 1'b1;
            slave_rdata_i[1] = 32'hC0DE_0001;
         end
         if (c == 3) begin
            slave_rvalid_i[0] = 1'b1;
            slave_rdata_i[0] = 32'hC0DE_0002;
         end
         #1;
         if (c < 3) begin
            vecs++; if (master_gnt_o[0] !== (c == 2 ? 1'b0 : (c == 3))) begin errs++; $display("FAIL ts_rom_gnt c%0d: got %b expected 0", c, master_gnt_o[0]); end
         end
         if (c == 2) begin
            vecs++; if (master_rvalid_o[0] !== 1'b1 || master_rdata_o[0] !== 32'hC0DE_0001) begin errs++; $display("FAIL ts_ram_resp: got %b/%h expected 1/c0de0001", master_rvalid_o[0], master_rdata_o[0]); end
         end
         if (c == 3) begin
            vecs++; if (master_rvalid_o[0] !== 1'b0) begin errs++; $display("FAIL ts_rom_idle: got %b expected 0", master_rvalid_o[0]); end
         end
      end
      // ROM request presented again after the RAM response has retired
      cyc();
      master_req_i[0] = 1'b1;
      master_addr_i[0] = 32'h0000_0200;
      slave_gnt_i[0] = 1'b1;
      #1;
      vecs++; if (master_gnt_o[0] !== 1'b1 || slave_req_o !== 3'b001) begin errs++; $display("FAIL ts_rom_gnt_after: got %b/%b expected 1/001", master_gnt_o[0], slave_req_o); end
      cyc();
      slave_rvalid_i[0] = 1'b1;
      slave_rdata_i[0] = 32'hC0DE_0003;
      #1;
      vecs++; if (master_rvalid_o[0] !== 1'b1 || master_rdata_o[0] !== 32'hC0DE_0003) begin errs++; $display("FAIL ts_rom_resp: got %b/%h expected 1/c0de0003", master_rvalid_o[0], master_rdata_o[0]); end
   endtask

   task automatic test_decode_error();
      for (int c = 0; c < 5; c++) begin
         cyc();
         if (c < 3) begin
            master_req_i[1] = 1'b1;
            master_we_i[1] = 1'b1;
            master_addr_i[1] = 32'hF000_0000;
            master_wdata_i[1] = 32'hDEAD_BEEF;
            slave_gnt_i = 3'b111;
         end
         #1;
         vecs++; if (master_gnt_o !== (c < 3 ? 3'b010 : 3'b000)) begin errs++; $display("FAIL de_gnt c%0d: got %b", c, master_gnt_o); end
         vecs++; if (slave_req_o !== 3'b000) begin errs++; $display("FAIL de_slave_req c%0d: got %b expected 000", c, slave_req_o); end
         vecs++; if (master_rvalid_o !== ((c >= 1 && c <= 3) ? 3'b010 : 3'b000)) begin errs++; $display("FAIL de_rvalid c%0d: got %b", c, master_rvalid_o); end
         vecs++; if (master_err_o !== ((c >= 1 && c <= 3) ? 3'b010 : 3'b000)) begin errs++; $display("FAIL de_err c%0d: got %b", c, master_err_o); end
         vecs++; if (master_rdata_o[1] !== 32'h0) begin errs++; $display("FAIL de_rdata c%0d: got %h expected 0", c, master_rdata_o[1]); end
      end
   endtask

   task automatic test_reset_midflight();
      for (int c = 0; c < 2; c++) begin
         cyc();
         master_req_i[0] = 1'b1;
         master_addr_i[0] = 32'h1000_0100 + 32'(4 * c);
         slave_gnt_i[1] = 1'b1;
         #1;
         vecs++; if (master_gnt_o[0] !== 1'b1) begin errs++; $display("FAIL rm_gnt c%0d: got %b expected 1", c, master_gnt_o[0]); end
      end
      cyc();
      rst_i = 1'b1;
      master_req_i[0] = 1'b1;
      master_addr_i[0] = 32'h1000_0100;
      slave_gnt_i[1] = 1'b1;
      slave_rvalid_i[1] = 1'b1;
      #1;
      vecs++; if ({master_gnt_o, master_rvalid_o, master_err_o, slave_req_o} !== 12'h0) begin errs++; $display("FAIL rm_in_reset: got %h expected 000", {master_gnt_o, master_rvalid_o, master_err_o, slave_req_o}); end
      cyc();
      rst_i = 1'b0;
      slave_rvalid_i[1] = 1'b1;
      slave_rdata_i[1] = 32'hBAD0_BAD0;
      #1;
      vecs++; if (master_rvalid_o !== 3'b000) begin errs++; $display("FAIL rm_late_rvalid: got %b expected 000", master_rvalid_o); end
      cyc();
      master_req_i[0] = 1'b1;
      master_addr_i[0] = 32'h1000_0200;
      slave_gnt_i[1] = 1'b1;
      #1;
      vecs++; if (master_gnt_o !== 3'b001) begin errs++; $display("FAIL rm_fresh_gnt: got %b expected 001", master_gnt_o); end
      cyc();
      slave_rvalid_i[1] = 1'b1;
      slave_rdata_i[1] = 32'h5555_AAAA;
      #1;
      vecs++; if (master_rvalid_o !== 3'b001 || master_rdata_o[0] !== 32'h5555_AAAA) begin errs++; $display("FAIL rm_fresh_resp: got %b/%h expected 001/5555aaaa", master_rvalid_o, master_rdata_o[0]); end
   endtask

   initial begin
      rst_i = 1'b1;
      master_req_i = '0; master_we_i = '0; master_be_i = '0;
      master_addr_i = '0; master_wdata_i = '0;
      slave_gnt_i = '0; slave_rvalid_i = '0; slave_rdata_i = '0;
      slave_addr_mask_i[0] = 32'hF000_0000; slave_addr_base_i[0] = 32'h0000_0000;
      slave_addr_mask_i[1] = 32'hF000_0000; slave_addr_base_i[1] = 32'h1000_0000;
      slave_addr_mask_i[2] = 32'hF000_0000; slave_addr_base_i[2] = 32'h2000_0000;
      test_reset();
      test_single_read();
      test_round_robin();
      test_outstanding();
      test_target_switch();
      test_decode_error();
      test_reset_midflight();
      cyc();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
